// File: rtl/switch_pkg.sv
// Shared types and constants for the switch egress drain stage.
package switch_pkg;

    localparam int NUM_OF_PORTS = 4;
    localparam int WORD_WIDTH   = 8;
    localparam int PORT_IDX_W   = $clog2(NUM_OF_PORTS);

    typedef logic [PORT_IDX_W-1:0] port_idx_t;

    typedef struct packed {
        port_idx_t             port;
        logic [WORD_WIDTH-1:0] data;
    } egress_entry_t;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        CAPTURE = 1'b1
    } drain_state_t;

    // Port index 'offset' positions after 'base', wrapping over the port count.
    function automatic port_idx_t rr_idx(input port_idx_t base, input int offset);
        rr_idx = port_idx_t'((int'(base) + offset) % NUM_OF_PORTS);
    endfunction

endpackage

// File: rtl/switch_egress_drain_fifo.sv
// Synchronous show-ahead FIFO of egress entries; head is visible whenever not empty.
module egress_fifo
    import switch_pkg::*;
#(
    parameter  int FIFO_SIZE = 64,
    localparam int PTR_W     = $clog2(FIFO_SIZE),
    localparam int CNT_W     = $clog2(FIFO_SIZE) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_i,
    input  egress_entry_t push_entry_i,
    input  logic          pop_i,
    output egress_entry_t head_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [CNT_W-1:0] count_o
);

    egress_entry_t    mem_q [FIFO_SIZE];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push_s;
    logic             do_pop_s;

    assign full_o    = (count_q == CNT_W'(FIFO_SIZE));
    assign empty_o   = (count_q == {CNT_W{1'b0}});
    assign do_push_s = push_i && !full_o;
    assign do_pop_s  = pop_i && !empty_o;
    assign count_o   = count_q;
    // Empty FIFO presents an all-zero head so outputs never show stale data.
    assign head_o    = empty_o ? '0 : mem_q[rd_ptr_q];

    // Next-state pointers and occupancy; push and pop together leave count unchanged.
    always_comb begin
        wr_ptr_d = do_push_s ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
        rd_ptr_d = do_pop_s  ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;
        case ({do_push_s, do_pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and count registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array write; contents need no reset because the count gates visibility.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_q[wr_ptr_q] <= push_entry_i;
        end
    end

endmodule

// File: rtl/switch_egress_drain.sv
// Drains switch output queues round-robin into one tagged byte stream via a FIFO.
module switch_egress_drain
    import switch_pkg::*;
#(
    parameter  int FIFO_SIZE = 64,
    localparam int CNT_W     = $clog2(FIFO_SIZE) + 1
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [NUM_OF_PORTS-1:0]            port_ready,
    input  logic [NUM_OF_PORTS*WORD_WIDTH-1:0] port_out,
    output logic [NUM_OF_PORTS-1:0]            port_read,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [WORD_WIDTH-1:0]              out_data,
    output logic [PORT_IDX_W-1:0]              out_port,
    output logic [CNT_W-1:0]                   fifo_count
);

    drain_state_t          state_q, state_d;
    port_idx_t             rr_ptr_q, rr_ptr_d;
    port_idx_t             grant_q, grant_d;
    logic [NUM_OF_PORTS-1:0] port_read_q, port_read_d;
    port_idx_t             grant_s;
    logic                  push_s;
    egress_entry_t         push_entry_s;
    egress_entry_t         head_s;
    logic                  full_s;
    logic                  empty_s;
    logic [WORD_WIDTH-1:0] port_byte_s [NUM_OF_PORTS];

    for (genvar i = 0; i < NUM_OF_PORTS; i++) begin : g_unpack
        assign port_byte_s[i] = port_out[i*WORD_WIDTH +: WORD_WIDTH];
    end

    // Round-robin pick: the lowest offset after rr_ptr with port_ready set wins.
    always_comb begin
        grant_s = rr_ptr_q;
        for (int off = NUM_OF_PORTS; off >= 1; off--) begin
            grant_s = port_ready[rr_idx(rr_ptr_q, off)] ? rr_idx(rr_ptr_q, off) : grant_s;
        end
    end

    // Drain FSM: issue one read from IDLE, capture the returned byte in CAPTURE.
    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        grant_d      = grant_q;
        port_read_d  = {NUM_OF_PORTS{1'b0}};
        push_s       = 1'b0;
        push_entry_s = '{port: grant_q, data: port_byte_s[grant_q]};
        case (state_q)
            IDLE: begin
                // Full is only checked here; the one read in flight always has a slot.
                if (!full_s && (|port_ready)) begin
                    port_read_d = {{(NUM_OF_PORTS-1){1'b0}}, 1'b1} << grant_s;
                    grant_d     = grant_s;
                    state_d     = CAPTURE;
                end else begin
                    state_d     = IDLE;
                end
            end
            CAPTURE: begin
                // The pop already happened upstream, so capture regardless of port_ready.
                push_s   = 1'b1;
                rr_ptr_d = grant_q;
                state_d  = IDLE;
            end
            default: begin
                state_d  = IDLE;
            end
        endcase
    end

    // FSM, arbitration and read-pulse registers; reset drops any byte in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rr_ptr_q    <= port_idx_t'(NUM_OF_PORTS - 1);
            grant_q     <= {PORT_IDX_W{1'b0}};
            port_read_q <= {NUM_OF_PORTS{1'b0}};
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_q     <= grant_d;
            port_read_q <= port_read_d;
        end
    end

    egress_fifo #(
        .FIFO_SIZE (FIFO_SIZE)
    ) u_fifo (
        .clk          (clk),
        .rst_n        (rst_n),
        .push_i       (push_s),
        .push_entry_i (push_entry_s),
        .pop_i        (out_valid && out_ready),
        .head_o       (head_s),
        .full_o       (full_s),
        .empty_o      (empty_s),
        .count_o      (fifo_count)
    );

    assign port_read = port_read_q;
    assign out_valid = !empty_s;
    assign out_data  = head_s.data;
    assign out_port  = head_s.port;

endmodule

// File: tb/tb_switch_egress_drain.sv
// Directed table-driven bench for switch_egress_drain plus multi-cycle corner sequences.
module tb_switch_egress_drain;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  port_ready;
    logic [31:0] port_out;
    logic [3:0]  port_read;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic [1:0]  out_port;
    logic [6:0]  fifo_count;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic        rst_n;
        logic [3:0]  rdy;
        logic [31:0] pout;
        logic        ordy;
        logic [3:0]  e_pr;
        logic        e_ov;
        logic [7:0]  e_od;
        logic [1:0]  e_op;
        logic [6:0]  e_cnt;
    } vec_t;

    vec_t tbl [17];

    switch_egress_drain dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .port_ready (port_ready),
        .port_out   (port_out),
        .port_read  (port_read),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_port   (out_port),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        port_ready = 4'b0000;
        out_ready  = 1'b0;
        step();
        rst_n      = 1'b1;
    endtask

    initial begin
        logic [3:0] prev;
        logic       b2b;
        logic       hit;
        int         reads;

        rst_n      = 1'b0;
        port_ready = 4'b0000;
        port_out   = 32'h13121110;
        out_ready  = 1'b1;

        // Cycle vectors: reset, single read of port 0, then round-robin over all ports.
        tbl[0]  = '{1'b0, 4'b0000, 32'h13121144, 1'b1, 4'b0000, 1'b0, 8'h00, 2'd0, 7'd0};
        tbl[1]  = '{1'b0, 4'b0000, 32'h13121144, 1'b1, 4'b0000, 1'b0, 8'h00, 2'd0, 7'd0};
        tbl[2]  = '{1'b1, 4'b0001, 32'h13121144, 1'b1, 4'b0001, 1'b0, 8'h00, 2'd0, 7'd0};
        tbl[3]  = '{1'b1, 4'b0000, 32'h13121144, 1'b1, 4'b0000, 1'b1, 8'h44, 2'd0, 7'd1};
        tbl[4]  = '{1'b1, 4'b0000, 32'h13121144, 1'b1, 4'b0000, 1'b0, 8'h00, 2'd0, 7'd0};
        tbl[5]  = '{1'b0, 4'b0000, 32'h13121110, 1'b1, 4'b0000, 1'b0, 8'h00, 2'd0, 7'd0};
        tbl[6]  = '{1'b1, 4'b1111, 32'h13121110, 1'b1, 4'b0001, 1'b0, 8'h00, 2'd0, 7'd0};
        tbl[7]  = '{1'b1, 4'b1111, 32'h13121110, 1'b1, 4'b0000, 1'b1, 8'h10, 2'd0, 7'd1};
        tbl[8]  = '{1'b1, 4'b1111, 32'h13121110, 1'b1, 4'b0010, 1'b0, 8'h00, 2'd0, 7'd0};
        tbl[9]  = '{1'b1, 4'b1111, 32'h13121110, 1'b1, 4'b0000, 1'b1, 8'h11, 2'd1, 7'd1};
        tbl[10] = '{1'b1, 4'b1111, 32'h13121110, 1'b1, 4'b0100, 1'b0, 8'h00, 2'd0, 7'd0};
        tbl[11] = '{1'b1, 4'b1111, 32'h13121110, 1'b1, 4'b0000, 1'b1, 8'h12, 2'd2, 7'd1};
        tbl[12] = '{1'b1, 4'b1111, 32'h13121110, 1'b1, 4'b1000, 1'b0, 8'h00, 2'd0, 7'd0};
        tbl[13] = '{1'b1, 4'b1111, 32'h13121110, 1'b1, 4'b0000, 1'b1, 8'h13, 2'd3, 7'd1};
        tbl[14] = '{1'b1, 4'b1111, 32'h13121110, 1'b1, 4'b0001, 1'b0, 8'h00, 2'd0, 7'd0};
        tbl[15] = '{1'b1, 4'b1111, 32'h13121110, 1'b1, 4'b0000, 1'b1, 8'h10, 2'd0, 7'd1};
        tbl[16] = '{1'b1, 4'b0000, 32'h13121110, 1'b1, 4'b0000, 1'b0, 8'h00, 2'd0, 7'd0};

        // Idle after reset: no reads, nothing valid, empty pops ignored.
        step();
        step();
        rst_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            step();
            chk("t1_idle", 32'({port_read, out_valid, fifo_count}), 32'({4'b0000, 1'b0, 7'd0}));
        end

        // Table-driven cycles.
        for (int i = 0; i < 17; i++) begin
            rst_n      = tbl[i].rst_n;
            port_ready = tbl[i].rdy;
            port_out   = tbl[i].pout;
            out_ready  = tbl[i].ordy;
            step();
            chk($sformatf("vec%0d", i),
                32'({port_read, out_valid, out_data, out_port, fifo_count}),
                32'({tbl[i].e_pr, tbl[i].e_ov, tbl[i].e_od, tbl[i].e_op, tbl[i].e_cnt}));
        end

        // Fill to full with the sink stalled, then free one slot.
        do_reset();
        port_out   = 32'h13121110;
        port_ready = 4'b0010;
        out_ready  = 1'b0;
        prev = 4'b0000;
        b2b  = 1'b0;
        hit  = 1'b0;
        for (int c = 0; c < 300 && !hit; c++) begin
            step();
            if (port_read != 4'b0000 && prev != 4'b0000) b2b = 1'b1;
            prev = port_read;
            if (fifo_count == 7'd64) hit = 1'b1;
        end
        chk("t4_full_count", 32'(fifo_count), 32'd64);
        chk("t4_no_b2b", 32'(b2b), 32'd0);
        for (int c = 0; c < 10; c++) begin
            step();
            chk("t4_hold", 32'({port_read, fifo_count}), 32'({4'b0000, 7'd64}));
        end
        chk("t4_head", 32'({out_valid, out_data, out_port}), 32'({1'b1, 8'h11, 2'd1}));
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("t4_pop_one", 32'({port_read, fifo_count}), 32'({4'b0000, 7'd63}));
        reads = 0;
        for (int c = 0; c < 6; c++) begin
            step();
            if (port_read != 4'b0000) reads++;
        end
        chk("t4_one_read", 32'(reads), 32'd1);
        chk("t4_refill", 32'(fifo_count), 32'd64);

        // Five entries queued, then push and pop on the same edge.
        do_reset();
        port_ready = 4'b0100;
        out_ready  = 1'b0;
        for (int k = 0; k < 5; k++) begin
            port_out = {8'h13, 8'hA0 + 8'(k), 8'h11, 8'h10};
            step();
            step();
        end
        chk("t5_count5", 32'({fifo_count, out_data, out_port}), 32'({7'd5, 8'hA0, 2'd2}));
        port_out = {8'h13, 8'hA5, 8'h11, 8'h10};
        step();
        out_ready = 1'b1;
        step();
        port_ready = 4'b0000;
        chk("t5_pushpop", 32'({fifo_count, out_data}), 32'({7'd5, 8'hA1}));
        for (int k = 2; k <= 5; k++) begin
            step();
            chk($sformatf("t5_order%0d", k), 32'({fifo_count, out_data, out_port}),
                32'({7'(6 - k), 8'hA0 + 8'(k), 2'd2}));
        end
        step();
        chk("t5_drained", 32'({out_valid, fifo_count}), 32'({1'b0, 7'd0}));

        // Reset while a byte is in flight: it is lost and the FSM restarts in IDLE.
        do_reset();
        port_out   = 32'h13121177;
        port_ready = 4'b0001;
        out_ready  = 1'b1;
        step();
        chk("t6_read", 32'(port_read), 32'(4'b0001));
        rst_n = 1'b0;
        step();
        chk("t6_in_reset", 32'({port_read, out_valid, fifo_count}), 32'({4'b0000, 1'b0, 7'd0}));
        rst_n      = 1'b1;
        port_ready = 4'b0000;
        step();
        chk("t6_discarded", 32'({port_read, out_valid, fifo_count}), 32'({4'b0000, 1'b0, 7'd0}));
        port_ready = 4'b0001;
        step();
        chk("t6_idle_again", 32'(port_read), 32'(4'b0001));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
